// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one downstream memory port between the fetch (imem) and
// data (dmem) requesters. Request pulses are held in one slot per requester,
// serialised downstream with one transaction in flight, and each response is
// routed back to the requester that owns the transaction. dmem has priority,
// but imem is granted after STARVE_LIMIT consecutive dmem grants while it waits.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] imem_addr,
  input  logic [3:0]  imem_rmask,
  output logic [31:0] imem_rdata,
  output logic        imem_resp,
  input  logic [31:0] dmem_addr,
  input  logic [3:0]  dmem_rmask,
  input  logic [3:0]  dmem_wmask,
  input  logic [31:0] dmem_wdata,
  output logic [31:0] dmem_rdata,
  output logic        dmem_resp,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_rmask,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_resp,
  output logic        protocol_err
);

  localparam logic [3:0] LIMIT = STARVE_LIMIT[3:0];

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT_I = 2'd1,
    WAIT_D = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Pending slots: valid bits are control (reset), payload is data (no reset).
  logic        i_vld_p0;
  logic [31:0] i_addr_p0;
  logic [3:0]  i_rmask_p0;
  logic        d_vld_p0;
  logic [31:0] d_addr_p0;
  logic [3:0]  d_rmask_p0;
  logic [3:0]  d_wmask_p0;
  logic [31:0] d_wdata_p0;

  logic [3:0]  starve_cnt;

  logic i_req, d_req, d_both;
  logic i_busy, d_busy;
  logic i_take, d_take;
  logic grant_i, grant_d;
  logic idle_resp;

  // Saturating increment of the starvation counter; never exceeds LIMIT.
  function automatic logic [3:0] starve_inc(input logic [3:0] cnt);
    if (cnt >= LIMIT) return LIMIT;
    return cnt + 4'd1;
  endfunction

  assign i_req  = (imem_rmask != 4'd0);
  assign d_req  = ((dmem_rmask | dmem_wmask) != 4'd0);
  assign d_both = (dmem_rmask != 4'd0) && (dmem_wmask != 4'd0);

  // A requester is busy while its slot holds a request or its transaction is
  // outstanding; the response cycle itself already counts as complete, so a
  // requester may re-request in the same cycle it sees its response.
  assign i_busy = i_vld_p0 || ((state_q == WAIT_I) && !mem_resp);
  assign d_busy = d_vld_p0 || ((state_q == WAIT_D) && !mem_resp);

  assign i_take = i_req && !i_busy;
  assign d_take = d_req && !d_busy;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state, arbitration and all port outputs.
  always_comb begin
    state_d    = state_q;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    idle_resp  = 1'b0;
    mem_addr   = 32'd0;
    mem_rmask  = 4'd0;
    mem_wmask  = 4'd0;
    mem_wdata  = 32'd0;
    imem_resp  = 1'b0;
    imem_rdata = 32'd0;
    dmem_resp  = 1'b0;
    dmem_rdata = 32'd0;
    case (state_q)
      IDLE: begin
        idle_resp = mem_resp;
        if (d_vld_p0 && !(i_vld_p0 && (starve_cnt == LIMIT))) begin
          grant_d   = 1'b1;
          mem_addr  = d_addr_p0;
          mem_rmask = d_rmask_p0;
          mem_wmask = d_wmask_p0;
          mem_wdata = d_wdata_p0;
          state_d   = WAIT_D;
        end else if (i_vld_p0) begin
          grant_i   = 1'b1;
          mem_addr  = i_addr_p0;
          mem_rmask = i_rmask_p0;
          state_d   = WAIT_I;
        end
      end
      WAIT_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          state_d    = IDLE;
        end
      end
      WAIT_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // imem slot valid: set on an accepted pulse, cleared when issued.
  always_ff @(posedge clk) begin
    if (rst)          i_vld_p0 <= 1'b0;
    else if (i_take)  i_vld_p0 <= 1'b1;
    else if (grant_i) i_vld_p0 <= 1'b0;
  end

  // imem slot payload capture.
  always_ff @(posedge clk) begin
    if (i_take) begin
      i_addr_p0  <= imem_addr;
      i_rmask_p0 <= imem_rmask;
    end
  end

  // dmem slot valid: set on an accepted pulse, cleared when issued.
  always_ff @(posedge clk) begin
    if (rst)          d_vld_p0 <= 1'b0;
    else if (d_take)  d_vld_p0 <= 1'b1;
    else if (grant_d) d_vld_p0 <= 1'b0;
  end

  // dmem slot payload capture; a read+write pulse is kept as a pure write.
  always_ff @(posedge clk) begin
    if (d_take) begin
      d_addr_p0  <= dmem_addr;
      d_rmask_p0 <= d_both ? 4'd0 : dmem_rmask;
      d_wmask_p0 <= dmem_wmask;
      d_wdata_p0 <= dmem_wdata;
    end
  end

  // Starvation counter: counts dmem grants that overtake a waiting fetch.
  always_ff @(posedge clk) begin
    if (rst)            starve_cnt <= 4'd0;
    else if (!i_vld_p0) starve_cnt <= 4'd0;
    else if (grant_i)   starve_cnt <= 4'd0;
    else if (grant_d)   starve_cnt <= starve_inc(starve_cnt);
  end

  // Sticky protocol error: dropped pulses, read+write pulses, stray responses.
  always_ff @(posedge clk) begin
    if (rst)
      protocol_err <= 1'b0;
    else if ((i_req && i_busy) || (d_req && d_busy) || d_both || idle_resp)
      protocol_err <= 1'b1;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter: each task drives one scenario and checks
// the combinational outputs at the falling edge of each cycle.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [31:0] imem_addr;
  logic [3:0]  imem_rmask;
  logic [31:0] imem_rdata;
  logic        imem_resp;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_rmask;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_resp;
  logic [31:0] mem_addr;
  logic [3:0]  mem_rmask;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_resp;
  logic        protocol_err;

  int passed = 0;
  int total  = 0;

  mem_arbiter #(.STARVE_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .imem_addr(imem_addr), .imem_rmask(imem_rmask),
    .imem_rdata(imem_rdata), .imem_resp(imem_resp),
    .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
    .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp),
    .protocol_err(protocol_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    imem_addr  = 32'd0;
    imem_rmask = 4'd0;
    dmem_addr  = 32'd0;
    dmem_rmask = 4'd0;
    dmem_wmask = 4'd0;
    dmem_wdata = 32'd0;
    mem_rdata  = 32'd0;
    mem_resp   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_in();
    repeat (3) step();
    @(negedge clk);
    total++; if (protocol_err !== 1'b0) $display("FAIL reset_err: got %b want 0", protocol_err); else passed++;
    total++; if ({imem_resp, dmem_resp} !== 2'b00) $display("FAIL reset_resp: got %b want 00", {imem_resp, dmem_resp}); else passed++;
    total++; if ({mem_rmask, mem_wmask} !== 8'h00) $display("FAIL reset_masks: got %h want 00", {mem_rmask, mem_wmask}); else passed++;
    total++; if ({mem_addr, mem_wdata} !== 64'd0) $display("FAIL reset_addr_wdata: got %h want 0", {mem_addr, mem_wdata}); else passed++;
    step();
    rst = 1'b0;
  endtask

  task automatic test_single_fetch();
    step(); clear_in();
    imem_rmask = 4'hF; imem_addr = 32'h1eceb000;            // cycle 1
    @(negedge clk);
    total++; if (mem_rmask !== 4'h0) $display("FAIL fetch_early_issue: got %h want 0", mem_rmask); else passed++;
    step(); clear_in();                                     // cycle 2
    @(negedge clk);
    total++; if (mem_rmask !== 4'hF) $display("FAIL fetch_issue_rmask: got %h want f", mem_rmask); else passed++;
    total++; if (mem_addr !== 32'h1eceb000) $display("FAIL fetch_issue_addr: got %h want 1eceb000", mem_addr); else passed++;
    step(); clear_in();                                     // cycle 3
    @(negedge clk);
    total++; if ({mem_rmask, mem_addr} !== 36'd0) $display("FAIL fetch_wait_quiet: got %h want 0", {mem_rmask, mem_addr}); else passed++;
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h00000013;             // cycle 4
    @(negedge clk);
    total++; if (imem_resp !== 1'b1) $display("FAIL fetch_resp: got %b want 1", imem_resp); else passed++;
    total++; if (imem_rdata !== 32'h00000013) $display("FAIL fetch_rdata: got %h want 00000013", imem_rdata); else passed++;
    total++; if (dmem_resp !== 1'b0) $display("FAIL fetch_dmem_resp: got %b want 0", dmem_resp); else passed++;
    step(); clear_in();                                     // cycle 5
    @(negedge clk);
    total++; if ({imem_resp, imem_rdata} !== 33'd0) $display("FAIL fetch_resp_drop: got %h want 0", {imem_resp, imem_rdata}); else passed++;
  endtask

  task automatic test_simultaneous();
    step(); clear_in();
    imem_rmask = 4'hF; imem_addr = 32'h1eceb004;
    dmem_wmask = 4'h3; dmem_addr = 32'h1eceb100; dmem_wdata = 32'hDEADBEEF;
    step(); clear_in();
    @(negedge clk);
    total++; if ({mem_rmask, mem_wmask} !== 8'h03) $display("FAIL simul_d_masks: got %h want 03", {mem_rmask, mem_wmask}); else passed++;
    total++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL simul_d_wdata: got %h want deadbeef", mem_wdata); else passed++;
    total++; if (mem_addr !== 32'h1eceb100) $display("FAIL simul_d_addr: got %h want 1eceb100", mem_addr); else passed++;
    step(); clear_in();
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h0;
    @(negedge clk);
    total++; if ({dmem_resp, imem_resp} !== 2'b10) $display("FAIL simul_d_resp: got %b want 10", {dmem_resp, imem_resp}); else passed++;
    total++; if (mem_rmask !== 4'h0) $display("FAIL simul_no_issue_on_resp: got %h want 0", mem_rmask); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if (mem_rmask !== 4'hF) $display("FAIL simul_i_rmask: got %h want f", mem_rmask); else passed++;
    total++; if (mem_addr !== 32'h1eceb004) $display("FAIL simul_i_addr: got %h want 1eceb004", mem_addr); else passed++;
    step(); clear_in();
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h12345678;
    @(negedge clk);
    total++; if (imem_rdata !== 32'h12345678) $display("FAIL simul_i_rdata: got %h want 12345678", imem_rdata); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if (protocol_err !== 1'b0) $display("FAIL simul_err: got %b want 0", protocol_err); else passed++;
  endtask

  task automatic test_starvation();
    logic [7:0] grants [8];
    logic [7:0] expect_g [6];
    int  ng = 0;
    int  wait_cnt = 0;
    logic last_d = 1'b0;
    for (int k = 0; k < 8; k++) grants[k] = 8'h3F;
    expect_g[0] = 8'h44; expect_g[1] = 8'h44; expect_g[2] = 8'h49;
    expect_g[3] = 8'h44; expect_g[4] = 8'h44; expect_g[5] = 8'h49;
    step(); clear_in();
    dmem_rmask = 4'hF; dmem_addr = 32'h1eceb300;
    imem_rmask = 4'hF; imem_addr = 32'h1eceb008;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (mem_rmask != 4'd0 || mem_wmask != 4'd0) begin
        last_d = (mem_addr == 32'h1eceb300);
        if (ng < 8) grants[ng] = last_d ? 8'h44 : 8'h49;
        ng++;
        wait_cnt = 3;
      end
      step(); clear_in();
      if (wait_cnt == 1) begin
        mem_resp = 1'b1; mem_rdata = 32'h0000_0100 + 32'(ng);
        if (ng < 6) begin
          if (last_d) begin dmem_rmask = 4'hF; dmem_addr = 32'h1eceb300; end
          else        begin imem_rmask = 4'hF; imem_addr = 32'h1eceb008; end
        end
      end
      if (wait_cnt > 0) wait_cnt--;
    end
    for (int k = 0; k < 6; k++) begin
      total++;
      if (grants[k] !== expect_g[k]) $display("FAIL starve_grant%0d: got %c want %c", k, grants[k], expect_g[k]);
      else passed++;
    end
    @(negedge clk);
    total++; if (protocol_err !== 1'b0) $display("FAIL starve_err: got %b want 0", protocol_err); else passed++;
  endtask

  task automatic test_protocol();
    int issues = 0;
    step(); clear_in();
    imem_rmask = 4'hF; imem_addr = 32'h1eceb010;
    step(); clear_in();
    @(negedge clk);
    total++; if (mem_rmask !== 4'hF) $display("FAIL proto_issue: got %h want f", mem_rmask); else passed++;
    step(); clear_in();
    imem_rmask = 4'hF; imem_addr = 32'h1eceb014;           // in flight: dropped
    @(negedge clk);
    total++; if (mem_rmask !== 4'h0) $display("FAIL proto_no_issue_inflight: got %h want 0", mem_rmask); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if (protocol_err !== 1'b1) $display("FAIL proto_err_set: got %b want 1", protocol_err); else passed++;
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h000000A5;
    @(negedge clk);
    total++; if (imem_resp !== 1'b1) $display("FAIL proto_resp: got %b want 1", imem_resp); else passed++;
    for (int c = 0; c < 4; c++) begin
      step(); clear_in();
      @(negedge clk);
      if (mem_rmask != 4'd0 || mem_wmask != 4'd0) issues++;
    end
    total++; if (issues !== 0) $display("FAIL proto_extra_issue: got %0d want 0", issues); else passed++;
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h0000DEAD;              // stray response in IDLE
    @(negedge clk);
    total++; if ({imem_resp, dmem_resp} !== 2'b00) $display("FAIL proto_idle_resp: got %b want 00", {imem_resp, dmem_resp}); else passed++;
    total++; if ({imem_rdata, dmem_rdata} !== 64'd0) $display("FAIL proto_idle_rdata: got %h want 0", {imem_rdata, dmem_rdata}); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if (protocol_err !== 1'b1) $display("FAIL proto_sticky: got %b want 1", protocol_err); else passed++;
    step(); clear_in();
    dmem_rmask = 4'hF; dmem_wmask = 4'hF; dmem_addr = 32'h1eceb020; dmem_wdata = 32'hCAFEF00D;
    step(); clear_in();
    @(negedge clk);
    total++; if ({mem_rmask, mem_wmask} !== 8'h0F) $display("FAIL proto_rw_as_write: got %h want 0f", {mem_rmask, mem_wmask}); else passed++;
    step(); clear_in();
    step(); clear_in();
    mem_resp = 1'b1;
    @(negedge clk);
    total++; if (dmem_resp !== 1'b1) $display("FAIL proto_rw_resp: got %b want 1", dmem_resp); else passed++;
    step(); clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++; if (protocol_err !== 1'b0) $display("FAIL proto_err_cleared: got %b want 0", protocol_err); else passed++;
  endtask

  task automatic test_reset_mid_wait();
    step(); clear_in();
    dmem_rmask = 4'hF; dmem_addr = 32'h1eceb400;
    step(); clear_in();
    @(negedge clk);
    total++; if (mem_rmask !== 4'hF) $display("FAIL rstw_issue: got %h want f", mem_rmask); else passed++;
    step(); clear_in();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    total++; if ({mem_rmask, mem_wmask, mem_addr, mem_wdata} !== 72'd0) $display("FAIL rstw_mem_out: got %h want 0", {mem_rmask, mem_wmask, mem_addr, mem_wdata}); else passed++;
    total++; if ({imem_resp, dmem_resp, protocol_err} !== 3'b000) $display("FAIL rstw_ctl: got %b want 000", {imem_resp, dmem_resp, protocol_err}); else passed++;
    step(); clear_in();
    imem_rmask = 4'hF; imem_addr = 32'h1eceb500;
    @(negedge clk);
    total++; if (mem_rmask !== 4'h0) $display("FAIL rstw_early: got %h want 0", mem_rmask); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if ({mem_rmask, mem_addr} !== {4'hF, 32'h1eceb500}) $display("FAIL rstw_fresh_issue: got %h want f1eceb500", {mem_rmask, mem_addr}); else passed++;
    step(); clear_in();
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h00500013;
    @(negedge clk);
    total++; if ({imem_resp, imem_rdata} !== {1'b1, 32'h00500013}) $display("FAIL rstw_fresh_resp: got %h want 100500013", {imem_resp, imem_rdata}); else passed++;
    step(); clear_in();
  endtask

  task automatic test_back_to_back();
    step(); clear_in();
    dmem_rmask = 4'h1; dmem_addr = 32'h1eceb200;
    step(); clear_in();
    @(negedge clk);
    total++; if ({mem_rmask, mem_addr} !== {4'h1, 32'h1eceb200}) $display("FAIL b2b_issue1: got %h want 11eceb200", {mem_rmask, mem_addr}); else passed++;
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h11111111;
    dmem_rmask = 4'h1; dmem_addr = 32'h1eceb201;
    @(negedge clk);
    total++; if ({dmem_resp, dmem_rdata} !== {1'b1, 32'h11111111}) $display("FAIL b2b_resp1: got %h want 111111111", {dmem_resp, dmem_rdata}); else passed++;
    total++; if (mem_rmask !== 4'h0) $display("FAIL b2b_gap: got %h want 0", mem_rmask); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if ({mem_rmask, mem_addr} !== {4'h1, 32'h1eceb201}) $display("FAIL b2b_issue2: got %h want 11eceb201", {mem_rmask, mem_addr}); else passed++;
    step(); clear_in();
    mem_resp = 1'b1; mem_rdata = 32'h22222222;
    @(negedge clk);
    total++; if ({dmem_resp, dmem_rdata} !== {1'b1, 32'h22222222}) $display("FAIL b2b_resp2: got %h want 122222222", {dmem_resp, dmem_rdata}); else passed++;
    total++; if (mem_rmask !== 4'h0) $display("FAIL b2b_single_cycle: got %h want 0", mem_rmask); else passed++;
    step(); clear_in();
    @(negedge clk);
    total++; if (protocol_err !== 1'b0) $display("FAIL b2b_err: got %b want 0", protocol_err); else passed++;
  endtask

  initial begin
    rst = 1'b1;
    clear_in();
    test_reset();
    test_single_fetch();
    test_simultaneous();
    test_starvation();
    test_protocol();
    test_reset_mid_wait();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one downstream memory port between the pipeline's instruction fetch requester (read-only) and data requester (read/write).
- Sits between the cpu's imem_*/dmem_* ports and a single unified memory or cache port.
- Latches one-cycle request pulses and serialises them downstream with one transaction in flight.
- Routes each response back to the requester that owns the transaction.
- dmem has priority, with a bounded starvation limit for imem.

Parameters:
STARVE_LIMIT, 2, max consecutive dmem grants issued while an imem request is pending; the next grant then goes to imem (1..15).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
imem_addr  in  32  fetch address, sampled when imem_rmask != 0
imem_rmask  in  4  fetch byte mask; nonzero for one cycle = request pulse
imem_rdata  out  32  fetch data, valid when imem_resp
imem_resp  out  1  one-cycle fetch completion
dmem_addr  in  32  data address, sampled on request pulse
dmem_rmask  in  4  load byte mask
dmem_wmask  in  4  store byte mask
dmem_wdata  in  32  store data, sampled on request pulse
dmem_rdata  out  32  load data, valid when dmem_resp
dmem_resp  out  1  one-cycle data completion
mem_addr  out  32  downstream address
mem_rmask  out  4  downstream read mask; nonzero for exactly one cycle per read issue
mem_wmask  out  4  downstream write mask; nonzero for exactly one cycle per write issue
mem_wdata  out  32  downstream store data
mem_rdata  in  32  downstream read data
mem_resp  in  1  downstream completion pulse
protocol_err  out  1  sticky protocol-violation flag

Behaviour:
- Request pulse definitions:
  - imem request pulse: imem_rmask != 0.
  - dmem request pulse: (dmem_rmask | dmem_wmask) != 0.
  - dmem with both rmask and wmask nonzero is illegal: sets protocol_err; treated as a write (rmask forced 0).
- Pending registers, one slot each for I and D:
  - On a request pulse the slot captures addr/masks/wdata and sets valid on the next edge.
- Protocol error, request side:
  - A pulse while that requester's slot is valid, or while its transaction is in flight, is dropped and sets protocol_err.
- FSM states:
  - IDLE: when any slot is valid, issue the chosen slot downstream for exactly one cycle (masks/addr/wdata from the slot), clear that slot, and go to WAIT_I or WAIT_D.
  - WAIT_I / WAIT_D: hold all mem_* masks at 0. On mem_resp, pulse imem_resp (or dmem_resp) combinationally in the same cycle, pass mem_rdata through, and return to IDLE.
  - A new issue happens no earlier than the cycle after the response.
- Arbitration in IDLE:
  - dmem slot wins unless the imem slot is valid and starve_cnt == STARVE_LIMIT; then imem wins.
  - starve_cnt (4-bit):
    - increments on each dmem grant while the imem slot is valid;
    - clears on every imem grant;
    - clears whenever the imem slot is empty;
    - saturates at STARVE_LIMIT.
- Latency:
  - Pulse at cycle t with the arbiter idle and no contention: mem_* issue at t+1.
  - Response is same-cycle with mem_resp.
- Idle outputs:
  - imem_rdata/dmem_rdata are 0 when the respective resp is low.
  - mem_addr/mem_wdata are 0 when no issue occurs.
- Simultaneous events:
  - A request pulse in the same cycle its slot is cleared by issue is not allowed (covered by the in-flight rule) and is flagged.
  - A pulse from the other requester in any cycle is always captured.
- Protocol error, response side: mem_resp in IDLE is ignored (no requester resp) and sets protocol_err.
- Reset (including mid-transaction), on the next edge:
  - state=IDLE; slots invalid; starve_cnt=0; protocol_err=0.
  - All outputs are 0: resp low, masks 0, addr/wdata/rdata 0.
  - A mem_resp for a transaction issued before reset arrives in IDLE: it is dropped and sets protocol_err.
  - The bench must therefore hold reset until downstream is quiet.

Test Plan:
- Single fetch:
  - Stimulus: imem_rmask=4'hF, addr=32'h1eceb000 at cycle 1; mem_resp at cycle 4 with rdata=32'h00000013.
  - Response: mem_rmask=F / addr=1eceb000 only at cycle 2; imem_resp=1 with imem_rdata=00000013 at cycle 4; dmem_resp stays 0.
- Simultaneous requests:
  - Stimulus: imem pulse (addr 1eceb004) and dmem store (wmask=4'h3, addr 1eceb100, wdata DEADBEEF) in the same cycle.
  - Response: dmem issued first (mem_wmask=3, mem_wdata=DEADBEEF); the imem read is issued the cycle after the dmem response.
- Starvation bound, STARVE_LIMIT=2:
  - Stimulus: imem pending; dmem re-requests on each response.
  - Response: grant order D, D, I, D, D, I.
- Protocol violations:
  - Stimulus: a second imem pulse while the fetch is in flight.
  - Response: pulse dropped, protocol_err=1 and sticky, no extra downstream issue.
  - Stimulus: mem_resp in IDLE.
  - Response: no requester resp.
- Reset mid-WAIT_D:
  - Stimulus: assert rst for 1 cycle.
  - Response: next cycle all outputs 0, state IDLE; a following fresh imem pulse issues normally at t+1.
- Back-to-back loads:
  - Stimulus: dmem_rmask=4'h1 at addr 1eceb200; after its resp, an immediate second load at 1eceb201.
  - Response: two separate one-cycle issues; dmem_rdata matches each mem_rdata; protocol_err=0.
